// File: rtl/core_bus_pkg.sv
// rtl/core_bus_pkg.sv - shared types and constants for the core bus router
package core_bus_pkg;

    localparam int          MAX_SLAVES        = 8;
    localparam int          IDX_W             = $clog2(MAX_SLAVES);
    localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_RESP
    } state_e;

    // Element type of the packed per-slave base/mask parameter arrays
    typedef logic [31:0] slv_addr_t;

endpackage

// File: rtl/core_bus_router_if.sv
// rtl/core_bus_router_if.sv - core-side and slave-side native memory bus interfaces
interface core_mem_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
                    input  mem_ready, mem_rdata);
    modport slave  (input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
                    output mem_ready, mem_rdata);
endinterface

interface core_slv_if #(parameter int NUM_SLAVES = 2);
    logic [NUM_SLAVES-1:0]    slv_valid;
    logic                     slv_instr;
    logic [31:0]              slv_addr;
    logic [31:0]              slv_wdata;
    logic [3:0]               slv_wstrb;
    logic [NUM_SLAVES-1:0]    slv_ready;
    logic [NUM_SLAVES*32-1:0] slv_rdata;

    modport master (output slv_valid, slv_instr, slv_addr, slv_wdata, slv_wstrb,
                    input  slv_ready, slv_rdata);
    modport slave  (input  slv_valid, slv_instr, slv_addr, slv_wdata, slv_wstrb,
                    output slv_ready, slv_rdata);
endinterface

// File: rtl/core_bus_decoder.sv
// rtl/core_bus_decoder.sv - address to slave match, lowest-index priority and miss flag
module core_bus_decoder
    import core_bus_pkg::*;
#(
    parameter int                           NUM_SLAVES = 2,
    parameter slv_addr_t [0:NUM_SLAVES-1]   SLV_BASE   = {32'h0000_0000, 32'h1000_0000},
    parameter slv_addr_t [0:NUM_SLAVES-1]   SLV_MASK   = {32'hFFFF_0000, 32'hF000_0000}
) (
    input  logic [31:0]           addr,
    output logic [NUM_SLAVES-1:0] match,
    output logic [IDX_W-1:0]      idx,
    output logic                  miss
);

    always_comb begin
        match = '0;
        idx   = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            match[i] = ((addr & SLV_MASK[i]) == SLV_BASE[i]);
        end
        // Walk downwards so the lowest matching index is the last writer
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (match[i]) begin
                idx = IDX_W'(i);
            end
        end
        miss = ~|match;
    end

endmodule

// File: rtl/core_bus_router.sv
// rtl/core_bus_router.sv - picorv32 native bus router with address windows and per-access timeout
module core_bus_router
    import core_bus_pkg::*;
#(
    parameter int                           NUM_SLAVES     = 2,
    parameter slv_addr_t [0:NUM_SLAVES-1]   SLV_BASE       = {32'h0000_0000, 32'h1000_0000},
    parameter slv_addr_t [0:NUM_SLAVES-1]   SLV_MASK       = {32'hFFFF_0000, 32'hF000_0000},
    parameter int                           TIMEOUT_CYCLES = 255,
    parameter logic [31:0]                  ERR_RDATA      = DEFAULT_ERR_RDATA
) (
    input  logic        clk,
    input  logic        resetn,
    core_mem_if.slave   mem,
    core_slv_if.master  slv,
    output logic        bus_err,
    output logic [31:0] err_addr,
    output logic [7:0]  err_count
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [NUM_SLAVES-1:0] dec_match;
    logic [IDX_W-1:0]      dec_idx;
    logic                  dec_miss;

    core_bus_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_decoder (
        .addr  (mem.mem_addr),
        .match (dec_match),
        .idx   (dec_idx),
        .miss  (dec_miss)
    );

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  instr_q, instr_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [NUM_SLAVES-1:0] slv_valid_q, slv_valid_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  bus_err_q, bus_err_d;
    logic [31:0]           err_addr_q, err_addr_d;
    logic [7:0]            err_count_q, err_count_d;

    logic                  sel_ready;
    logic [31:0]           sel_rdata;

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_ready = slv.slv_ready[i];
                sel_rdata = slv.slv_rdata[i*32 +: 32];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        instr_d     = instr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        slv_valid_d = slv_valid_q;
        cnt_d       = cnt_q;
        ready_d     = 1'b0;
        rdata_d     = rdata_q;
        bus_err_d   = 1'b0;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (mem.mem_valid) begin
                    idx_d   = dec_idx;
                    instr_d = mem.mem_instr;
                    addr_d  = mem.mem_addr;
                    wdata_d = mem.mem_wdata;
                    wstrb_d = mem.mem_wstrb;
                    cnt_d   = '0;
                    if (!dec_miss) begin
                        state_d     = ST_DRIVE;
                        slv_valid_d = '0;
                        for (int i = 0; i < NUM_SLAVES; i++) begin
                            if (dec_idx == IDX_W'(i)) begin
                                slv_valid_d[i] = 1'b1;
                            end
                        end
                    end else begin
                        state_d     = ST_RESP;
                        ready_d     = 1'b1;
                        rdata_d     = ERR_RDATA;
                        bus_err_d   = 1'b1;
                        err_addr_d  = mem.mem_addr;
                        err_count_d = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;
                    end
                end
            end
            ST_DRIVE: begin
                // Ready is checked first so it beats a coincident expiry
                if (sel_ready) begin
                    state_d     = ST_RESP;
                    slv_valid_d = '0;
                    ready_d     = 1'b1;
                    rdata_d     = sel_rdata;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d     = ST_RESP;
                    slv_valid_d = '0;
                    ready_d     = 1'b1;
                    rdata_d     = ERR_RDATA;
                    bus_err_d   = 1'b1;
                    err_addr_d  = addr_q;
                    err_count_d = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                slv_valid_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            instr_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            slv_valid_q <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            bus_err_q   <= 1'b0;
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            instr_q     <= instr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            slv_valid_q <= slv_valid_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            bus_err_q   <= bus_err_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign mem.mem_ready = ready_q;
    assign mem.mem_rdata = rdata_q;
    assign slv.slv_valid = slv_valid_q;
    assign slv.slv_instr = instr_q;
    assign slv.slv_addr  = addr_q;
    assign slv.slv_wdata = wdata_q;
    assign slv.slv_wstrb = wstrb_q;
    assign bus_err       = bus_err_q;
    assign err_addr      = err_addr_q;
    assign err_count     = err_count_q;

endmodule
